// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects the active-low
// DE-series pushbuttons. Each key gets a two-flop synchroniser, a four-state
// debounce FSM with its own stability counter, and registered level/press/
// release outputs.
// Optional build macro KEY_AUTOREPEAT_EN adds per-key auto-repeat press pulses
// while a key is held down.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released
);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_DN_WAIT = 2'd1,
    ST_DOWN    = 2'd2,
    ST_UP_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 ||
      64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_conditioner: repeat parameters must be at least 1");
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCNT_W-1:0] RDELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic [RCNT_W-1:0]   rcnt_q [NUM_KEYS];
  logic [RCNT_W-1:0]   rcnt_d [NUM_KEYS];
  // 0 = waiting for the initial delay, 1 = in the periodic repeat phase
  logic [NUM_KEYS-1:0] rphase_q, rphase_d;
`endif

  logic [NUM_KEYS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_KEYS-1:0] key_act;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] key_pressed_q, key_pressed_d;
  logic [NUM_KEYS-1:0] key_released_q, key_released_d;

  // Synchroniser next state; key_act is the synchronised key, 1 = pressed.
  always_comb begin
    s1_d    = KEY;
    s2_d    = s1_q;
    key_act = ~s2_q;
  end

  // Per-key debounce FSM next state, counters and output pulses.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    key_down_d     = key_down_q;
    key_pressed_d  = '0;
    key_released_d = '0;
`ifdef KEY_AUTOREPEAT_EN
    rcnt_d         = rcnt_q;
    rphase_d       = rphase_q;
`endif
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      case (state_q[i])
        ST_UP: begin
          if (key_act[i]) begin
            state_d[i] = ST_DN_WAIT;
            cnt_d[i]   = '0;
          end
        end
        ST_DN_WAIT: begin
          if (!key_act[i]) begin
            state_d[i] = ST_UP;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]       = ST_DOWN;
            cnt_d[i]         = '0;
            key_down_d[i]    = 1'b1;
            key_pressed_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d[i]        = '0;
            rphase_d[i]      = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (!key_act[i]) begin
            state_d[i] = ST_UP_WAIT;
            cnt_d[i]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (!rphase_q[i]) begin
            // Initial hold delay before the first repeat pulse.
            if (rcnt_q[i] == RDELAY_LAST) begin
              key_pressed_d[i] = 1'b1;
              rcnt_d[i]        = '0;
              rphase_d[i]      = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
            end
          end else begin
            if (rcnt_q[i] == RPERIOD_LAST) begin
              key_pressed_d[i] = 1'b1;
              rcnt_d[i]        = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
            end
          end
`endif
        end
        ST_UP_WAIT: begin
          if (key_act[i]) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]        = ST_UP;
            cnt_d[i]          = '0;
            key_down_d[i]     = 1'b0;
            key_released_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q           <= '1;
      s2_q           <= '1;
      key_down_q     <= '0;
      key_pressed_q  <= '0;
      key_released_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state_q[i] <= ST_UP;
        cnt_q[i]   <= '0;
      end
`ifdef KEY_AUTOREPEAT_EN
      rphase_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        rcnt_q[i] <= '0;
      end
`endif
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      key_down_q     <= key_down_d;
      key_pressed_q  <= key_pressed_d;
      key_released_q <= key_released_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
`ifdef KEY_AUTOREPEAT_EN
      rphase_q <= rphase_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        rcnt_q[i] <= rcnt_d[i];
      end
`endif
    end
  end

  assign key_down     = key_down_q;
  assign key_pressed  = key_pressed_q;
  assign key_released = key_released_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: a table of per-cycle vectors plus
// hand-written sequences for bounce, glitch, reset-abort and repeat cases.
module tb_key_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] key;
  logic [3:0] key_down, key_pressed, key_released;
  logic [0:0] key2;
  logic [0:0] key_down2, key_pressed2, key_released2;

  int checks   = 0;
  int failures = 0;

  key_conditioner #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .CNT_W(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(key),
    .key_down(key_down), .key_pressed(key_pressed), .key_released(key_released)
  );

  key_conditioner #(
    .NUM_KEYS(1), .DEBOUNCE_CYCLES(2), .CNT_W(3),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut2 (
    .CLOCK_50(clk), .reset(reset), .KEY(key2),
    .key_down(key_down2), .key_pressed(key_pressed2), .key_released(key_released2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         n;
    logic [3:0] down;
    logic [3:0] pr;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  logic [3:0] exp_v;

  initial begin
    // Press key0 / release; then all keys together, press and release.
    vecs[0]  = '{4'b1110, 6, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1110, 1, 4'b0001, 4'b0001, 4'b0000};
    vecs[2]  = '{4'b1110, 2, 4'b0001, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1111, 6, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0000, 1, 4'b1111, 4'b1111, 4'b0000};
    vecs[8]  = '{4'b0000, 2, 4'b1111, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b1111, 6, 4'b1111, 4'b0000, 4'b0000};
    vecs[10] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b1111};
    vecs[11] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};

    // Reset state.
    reset = 1'b1;
    key   = 4'b1111;
    key2  = 1'b1;
    repeat (3) tick();
    chk("rst_down",  key_down, 4'b0000);
    chk("rst_press", key_pressed, 4'b0000);
    chk("rst_rel",   key_released, 4'b0000);
    chk("rst_down2", {3'b000, key_down2}, 4'b0000);
    reset = 1'b0;

    // Table-driven press/release latency and simultaneous keys.
    for (int v = 0; v < 12; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        key = vecs[v].key;
        tick();
        chk($sformatf("vec%0d_down", v),  key_down,     vecs[v].down);
        chk($sformatf("vec%0d_press", v), key_pressed,  vecs[v].pr);
        chk($sformatf("vec%0d_rel", v),   key_released, vecs[v].rel);
      end
    end

    // Bouncing key1: 3 low, 1 high, repeated, must never be accepted.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 4; c++) begin
        key[1] = (c < 3) ? 1'b0 : 1'b1;
        tick();
        chk("bounce_down1",  {3'b000, key_down[1]}, 4'b0000);
        chk("bounce_press1", {3'b000, key_pressed[1]}, 4'b0000);
      end
    end
    key[1] = 1'b1;
    repeat (4) tick();
    chk("bounce_settle", key_down, 4'b0000);

    // Key2 press, then release with a 2-cycle glitch.
    key[2] = 1'b0;
    repeat (6) tick();
    tick();
    chk("k2_press", key_pressed, 4'b0100);
    tick();
    chk("k2_down", key_down, 4'b0100);
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      key[2] = (j == 2 || j == 3) ? 1'b0 : 1'b1;
      tick();
      if (key_released[2]) pulses++;
      chk($sformatf("glitch_rel_j%0d", j),  {3'b000, key_released[2]}, {3'b000, (j == 10)});
      chk($sformatf("glitch_down_j%0d", j), {3'b000, key_down[2]},     {3'b000, (j < 10)});
      chk("glitch_press", key_pressed, 4'b0000);
    end
    chk("glitch_pulses", 4'(pulses), 4'd1);

    // Reset mid-debounce on key3 while key0 is already held down.
    key[0] = 1'b0;
    repeat (8) tick();
    chk("pre_rst_down", key_down, 4'b0001);
    key[3] = 1'b0;
    repeat (5) tick();
    chk("k3_in_wait", key_down, 4'b0001);
    reset = 1'b1;
    tick();
    chk("mid_rst_down",  key_down, 4'b0000);
    chk("mid_rst_press", key_pressed, 4'b0000);
    chk("mid_rst_rel",   key_released, 4'b0000);
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = (k == 7) ? 4'b1001 : 4'b0000;
      chk($sformatf("post_rst_press_k%0d", k), key_pressed, exp_v);
      exp_v = (k >= 7) ? 4'b1001 : 4'b0000;
      chk($sformatf("post_rst_down_k%0d", k), key_down, exp_v);
      chk("post_rst_rel", key_released, 4'b0000);
    end
    key = 4'b1111;
    repeat (10) tick();
    chk("final_idle", key_down, 4'b0000);

    // Held key on the DEBOUNCE_CYCLES=2 instance: single pulse or repeats.
    pulses = 0;
    key2 = 1'b0;
    for (int j = 0; j < 25; j++) begin
      tick();
`ifdef KEY_AUTOREPEAT_EN
      exp_v = {3'b000, (j == 4 || j == 14 || j == 17 || j == 20 || j == 23)};
`else
      exp_v = {3'b000, (j == 4)};
`endif
      if (key_pressed2[0]) pulses++;
      chk($sformatf("hold_press_j%0d", j), {3'b000, key_pressed2}, exp_v);
      chk($sformatf("hold_down_j%0d", j),  {3'b000, key_down2}, {3'b000, (j >= 4)});
    end
`ifdef KEY_AUTOREPEAT_EN
    chk("hold_pulses", 4'(pulses), 4'd5);
`else
    chk("hold_pulses", 4'(pulses), 4'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
